// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: captures one request, waits a programmable
// number of cycles, then commits a write or returns read data with a one-cycle ready pulse.
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            mem_req,
    input  logic [31:0]     mem_addr,
    input  logic            mem_write_en,
    input  logic [0:3][7:0] mem_data_in,
    output logic [0:3][7:0] mem_data_out,
    output logic            mem_ready,
    output logic            busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic [0:3][7:0] wdata_q, wdata_d;
    logic [0:3][7:0] rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            accept;
    logic            commit;
    logic            addr_unused;

    logic [0:3][7:0] storage [DEPTH];

    // Only the word index bits matter; the rest wrap away.
    assign addr_unused = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: accept = mem_req;
            BUSY: begin
                if (count_q == '0) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                accept = mem_req;
                if (!mem_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // The captured copy is what the whole access uses, so later input changes are harmless.
        if (accept) begin
            idx_d   = mem_addr[AW+1:2];
            we_d    = mem_write_en;
            wdata_d = mem_data_in;
            count_d = CNT_LOAD;
            state_d = BUSY;
        end
        if (commit && !we_q) rdata_d = storage[idx_q];
        ready_d = (state_d == DONE);
        busy_d  = (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset so its contents survive rst_b.
    always_ff @(posedge clk) begin
        if (commit && we_q) storage[idx_q] <= wdata_q;
    end

    assign mem_data_out = rdata_q;
    assign mem_ready    = ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=4 instance for the main
// behaviour and a LATENCY=1 instance for the minimum-latency build.
module tb_data_mem_responder;

    logic            clk;
    logic            rst_b;
    logic            req, we, ready, busy;
    logic [31:0]     addr;
    logic [0:3][7:0] din, dout;
    logic            req1, we1, ready1, busy1;
    logic [31:0]     addr1;
    logic [0:3][7:0] din1, dout1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [0:3][7:0] model [1024];
    logic [0:3][7:0] last_read;
    logic [0:3][7:0] sb_q [$];

    data_mem_responder #(.DEPTH(1024), .LATENCY(4)) dut (
        .clk(clk), .rst_b(rst_b), .mem_req(req), .mem_addr(addr),
        .mem_write_en(we), .mem_data_in(din), .mem_data_out(dout),
        .mem_ready(ready), .busy(busy)
    );

    data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .mem_req(req1), .mem_addr(addr1),
        .mem_write_en(we1), .mem_data_in(din1), .mem_data_out(dout1),
        .mem_ready(ready1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference model: writes update storage, reads update the held output value.
    function automatic logic [0:3][7:0] predict(input logic [31:0] a, input logic w,
                                                input logic [0:3][7:0] d);
        if (w) model[a[11:2]] = d;
        else   last_read = model[a[11:2]];
        return last_read;
    endfunction

    task automatic access(input logic [31:0] a, input logic w, input logic [0:3][7:0] d,
                          output int lat, output int busy_cnt, output logic [0:3][7:0] rd);
        lat = -1;
        busy_cnt = 0;
        rd = '0;
        @(posedge clk); #1;
        req = 1'b1; addr = a; we = w; din = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'bx; din = 32'h5A5A_5A5A;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (ready) begin
                lat = i;
                rd = dout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        #1;
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++;
        if (dout !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_dout: got %h expected 00000000", dout); end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_write_read();
        int lat, bc;
        logic [0:3][7:0] rd, exp;
        sb_q.push_back(predict(32'h10, 1'b1, {8'h11, 8'h22, 8'h33, 8'h44}));
        access(32'h10, 1'b1, {8'h11, 8'h22, 8'h33, 8'h44}, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("[TB] FAIL write_latency: got %0d expected 5", lat); end
        tests_run++;
        if (bc !== 4) begin tests_failed++; $display("[TB] FAIL write_busy_cycles: got %0d expected 4", bc); end
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL write_dout: got %h expected %h", rd, exp); end
        @(negedge clk);
        tests_run++;
        if (ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL ready_single_pulse: got %b expected 0", ready); end

        sb_q.push_back(predict(32'h10, 1'b0, '0));
        access(32'h10, 1'b0, '0, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("[TB] FAIL read_latency: got %0d expected 5", lat); end
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL read_data: got %h expected %h", rd, exp); end

        sb_q.push_back(predict(32'h13, 1'b0, '0));
        access(32'h13, 1'b0, '0, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL read_low_bits_ignored: got %h expected %h", rd, exp); end
    endtask

    task automatic test_wrap();
        int lat, bc;
        logic [0:3][7:0] rd, exp;
        sb_q.push_back(predict(32'h1010, 1'b1, {8'hDD, 8'hCC, 8'hBB, 8'hAA}));
        access(32'h1010, 1'b1, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL wrap_write_dout: got %h expected %h", rd, exp); end
        sb_q.push_back(predict(32'h10, 1'b0, '0));
        access(32'h10, 1'b0, '0, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL wrap_read: got %h expected %h", rd, exp); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int first = -1;
        int second = -1;
        logic [0:3][7:0] exp;
        sb_q.push_back(predict(32'h20, 1'b1, {8'h01, 8'h02, 8'h03, 8'h04}));
        sb_q.push_back(predict(32'h20, 1'b0, '0));
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h20; din = {8'h01, 8'h02, 8'h03, 8'h04};
        @(posedge clk); #1;
        we = 1'b0; din = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (first < 0) first = i; else if (second < 0) second = i;
                if (sb_q.size() > 0) begin
                    exp = sb_q.pop_front();
                    tests_run++;
                    if (dout !== exp) begin tests_failed++; $display("[TB] FAIL b2b_data_%0d: got %h expected %h", pulses, dout, exp); end
                end
                if (pulses == 1) begin
                    @(posedge clk); #1;
                    req = 1'b0;
                end
            end
        end
        tests_run++;
        if (pulses !== 2) begin tests_failed++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 2", pulses); end
        tests_run++;
        if (second - first !== 5) begin tests_failed++; $display("[TB] FAIL b2b_spacing: got %0d expected 5", second - first); end
        sb_q.delete();
    endtask

    task automatic test_busy_drop();
        int pulses = 0;
        logic [0:3][7:0] rd = '0;
        logic [0:3][7:0] exp;
        sb_q.push_back(predict(32'h20, 1'b0, '0));
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h20;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h10; din = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (pulses == 1) rd = dout;
            end
        end
        exp = sb_q.pop_front();
        tests_run++;
        if (pulses !== 1) begin tests_failed++; $display("[TB] FAIL busy_req_dropped: got %0d pulses expected 1", pulses); end
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL busy_drop_data: got %h expected %h", rd, exp); end
    endtask

    task automatic test_reset_mid_write();
        int lat, bc;
        int pulses = 0;
        logic [0:3][7:0] rd, exp;
        sb_q.push_back(predict(32'h30, 1'b1, '0));
        access(32'h30, 1'b1, '0, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL pre_clear_dout: got %h expected %h", rd, exp); end
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h30; din = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        @(posedge clk); #1;
        req = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_write_busy: got %b expected 1", busy); end
        rst_b = 1'b0;
        last_read = '0;
        #1;
        tests_run++;
        if ({busy, ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL async_reset_flags: got %b expected 00", {busy, ready}); end
        tests_run++;
        if (dout !== 32'h0) begin tests_failed++; $display("[TB] FAIL async_reset_dout: got %h expected 00000000", dout); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 2) rst_b = 1'b1;
            if (ready) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin tests_failed++; $display("[TB] FAIL reset_no_ready: got %0d pulses expected 0", pulses); end
        sb_q.push_back(predict(32'h30, 1'b0, '0));
        access(32'h30, 1'b0, '0, lat, bc, rd);
        exp = sb_q.pop_front();
        tests_run++;
        if (rd !== exp) begin tests_failed++; $display("[TB] FAIL write_discarded: got %h expected %h", rd, exp); end
    endtask

    task automatic test_latency1();
        int lat = -1;
        int pulses = 0;
        int prev = 0;
        int bad_gap = 0;
        logic [0:3][7:0] exp;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h40; din1 = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        sb_q.push_back({8'hA1, 8'hA2, 8'hA3, 8'hA4});
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ready1) begin lat = i; break; end
        end
        exp = sb_q.pop_front();
        tests_run++;
        if (lat !== 2) begin tests_failed++; $display("[TB] FAIL lat1_latency: got %0d expected 2", lat); end
        tests_run++;
        if (dout1 !== exp) begin tests_failed++; $display("[TB] FAIL lat1_read: got %h expected %h", dout1, exp); end
        @(posedge clk); #1;
        req1 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ready1) begin
                pulses++;
                if (prev != 0 && i - prev != 2) bad_gap++;
                prev = i;
            end
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (pulses !== 6) begin tests_failed++; $display("[TB] FAIL lat1_stream_count: got %0d expected 6", pulses); end
        tests_run++;
        if (bad_gap !== 0) begin tests_failed++; $display("[TB] FAIL lat1_stream_gap: got %0d bad gaps expected 0", bad_gap); end
    endtask

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; din = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
        last_read = '0;
        for (int i = 0; i < 1024; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_wrap();
        test_back_to_back();
        test_busy_drop();
        test_reset_mid_write();
        test_latency1();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
